// File: rtl/vertex_transform_mac.sv
`default_nettype none
// ============================================================================
// Module      : vertex_transform_mac
// Description : Fixed-point DIMxDIM matrix * vector transform using a single
//               sequential multiply-accumulate, with per-vector saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vertex_transform_mac #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int DIM   = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              mat_we_in,
    input  logic [$clog2(DIM*DIM)-1:0]        mat_addr_in,
    input  logic [WIDTH-1:0]                  mat_data_in,
    input  logic [DIM-1:0][WIDTH-1:0]         pos_in,
    input  logic                              valid_in,
    output logic                              ready_out,
    output logic [DIM-1:0][WIDTH-1:0]         new_pos_out,
    output logic                              valid_out,
    input  logic                              ready_in,
    output logic                              sat_out
);

    localparam int c_AW    = $clog2(DIM*DIM);
    localparam int c_CW    = $clog2(DIM);
    localparam int c_ACC_W = 2*WIDTH + $clog2(DIM);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COMPUTE = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1) << FRAC;
    localparam logic signed [c_ACC_W-1:0] c_MAX =
        {{(c_ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_MIN =
        {{(c_ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [1:0]                   r_state;
    logic [1:0]                   w_next;
    logic                         w_ready;
    logic                         w_valid;
    logic                         w_accept;
    logic                         w_mac;
    logic                         w_last_col;
    logic                         w_last;
    logic [WIDTH-1:0]             r_mat [DIM*DIM];
    logic [DIM-1:0][WIDTH-1:0]    r_pos;
    logic [DIM-1:0][WIDTH-1:0]    r_new;
    logic [c_CW-1:0]              r_row;
    logic [c_CW-1:0]              r_col;
    logic signed [c_ACC_W-1:0]    r_acc;
    logic                         r_sat;
    logic [c_AW-1:0]              w_idx;
    logic signed [2*WIDTH-1:0]    w_coef_x;
    logic signed [2*WIDTH-1:0]    w_pos_x;
    logic signed [2*WIDTH-1:0]    w_prod;
    logic signed [c_ACC_W-1:0]    w_sum;
    logic signed [c_ACC_W-1:0]    w_shift;
    logic [WIDTH-1:0]             w_row;
    logic                         w_row_sat;

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= c_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_ready = 1'b1;
                if (valid_in) w_next = c_COMPUTE;
            end
            c_COMPUTE: begin
                if (w_last) w_next = c_DONE;
            end
            c_DONE: begin
                w_valid = 1'b1;
                w_ready = ready_in;
                if (ready_in) w_next = valid_in ? c_COMPUTE : c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    assign w_accept   = w_ready & valid_in;
    assign w_mac      = (r_state == c_COMPUTE);
    assign w_last_col = (r_col == c_CW'(DIM-1));
    assign w_last     = w_last_col && (r_row == c_CW'(DIM-1));

    // Coefficients are writable only while idle, so a write on the accepting
    // edge lands before the first MAC reads it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DIM*DIM; i++)
                r_mat[i] <= ((i / DIM) == (i % DIM)) ? c_ONE : '0;
        end else if (mat_we_in && (r_state == c_IDLE)) begin
            r_mat[mat_addr_in] <= mat_data_in;
        end
    end

    assign w_idx    = c_AW'(r_row * DIM + r_col);
    assign w_coef_x = {{WIDTH{r_mat[w_idx][WIDTH-1]}}, r_mat[w_idx]};
    assign w_pos_x  = {{WIDTH{r_pos[r_col][WIDTH-1]}}, r_pos[r_col]};
    assign w_prod   = w_coef_x * w_pos_x;
    assign w_sum    = r_acc + {{(c_ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    assign w_shift  = w_sum >>> FRAC;

    always_comb begin
        w_row     = w_shift[WIDTH-1:0];
        w_row_sat = 1'b0;
        if (w_shift > c_MAX) begin
            w_row     = c_MAX[WIDTH-1:0];
            w_row_sat = 1'b1;
        end else if (w_shift < c_MIN) begin
            w_row     = c_MIN[WIDTH-1:0];
            w_row_sat = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pos <= '0;
            r_new <= '0;
            r_row <= '0;
            r_col <= '0;
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_pos <= pos_in;
            r_row <= '0;
            r_col <= '0;
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_mac) begin
            if (w_last_col) begin
                r_new[r_row] <= w_row;
                r_sat        <= r_sat | w_row_sat;
                r_acc        <= '0;
                r_col        <= '0;
                r_row        <= r_row + 1'b1;
            end else begin
                r_acc <= w_sum;
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign ready_out   = w_ready;
    assign valid_out   = w_valid;
    assign new_pos_out = r_new;
    assign sat_out     = r_sat;

endmodule
`default_nettype wire

// File: doc/vertex_transform_mac.md
VERTEX_TRANSFORM_MAC -- requirements
Module: vertex_transform_mac

Interface
REQ-001 Parameter WIDTH, default 32: signed two's-complement fixed-point word width.
REQ-002 Parameter FRAC, default 16: fractional bits (1.0 = 1<<FRAC).
REQ-003 Parameter DIM, default 4, range 2..4: vector length and matrix order.
REQ-004 clk_in  input  1: single clock; all logic rising-edge.
REQ-005 rst_in  input  1: synchronous, active-high reset.
REQ-006 mat_we_in  input  1: matrix coefficient write strobe.
REQ-007 mat_addr_in  input  clog2(DIM*DIM): coefficient address, r*DIM+c.
REQ-008 mat_data_in  input  WIDTH: coefficient M[r][c].
REQ-009 pos_in  input  DIM x WIDTH: input vector; pos_in[DIM-1]=x … pos_in[0]=w.
REQ-010 valid_in  input  1: pos_in valid.
REQ-011 ready_out  output  1: block accepts pos_in this cycle.
REQ-012 new_pos_out  output  DIM x WIDTH: transformed vector, same index order.
REQ-013 valid_out  output  1: new_pos_out valid.
REQ-014 ready_in  input  1: downstream accepts new_pos_out.
REQ-015 sat_out  output  1: some component of current new_pos_out saturated; qualified by valid_out.

Function
REQ-016 new_pos_out[r] SHALL equal sat(sum over c of M[r][c]*pos_in[c] >>> FRAC), arithmetic shift (round toward -inf).
REQ-017 Products full 2*WIDTH bits; accumulator 2*WIDTH+clog2(DIM) bits; no intermediate overflow.
REQ-018 sat(): above 2^(WIDTH-1)-1 clamps to max; below -2^(WIDTH-1) clamps to min.
REQ-019 One multiplier, one MAC per cycle, order r=0..DIM-1 outer, c=0..DIM-1 inner.
REQ-020 FSM states IDLE, COMPUTE, DONE.
REQ-021 IDLE: ready_out=1; valid_in high at an edge latches pos_in, clears accumulator, r=c=0, clears sat, goes COMPUTE.
REQ-022 COMPUTE: one MAC per edge; at c=DIM-1 saturated row result written to new_pos_out[r], accumulator cleared, r increments; after last MAC goes DONE.
REQ-023 Latency: valid_out high exactly DIM*DIM cycles after accepting edge (16 for DIM=4).
REQ-024 DONE: valid_out=1; new_pos_out and sat_out held stable until ready_in high.
REQ-025 DONE with ready_in=1: ready_out=1; if valid_in also high, new vector accepted same edge (back-to-back, period DIM*DIM+1), else goes IDLE.
REQ-026 ready_out=0 in COMPUTE and in DONE with ready_in=0; valid_in ignored then.
REQ-027 Matrix writes honoured only in IDLE; ignored in COMPUTE and DONE.
REQ-028 Write and acceptance on same IDLE edge: write takes effect before the first MAC.
REQ-029 new_pos_out rows not yet written in COMPUTE keep previous values; undefined to consumers while valid_out=0.

Reset
REQ-030 rst_in high at edge: state IDLE, valid_out=0, sat_out=0, new_pos_out=0, accumulator=0, r=c=0.
REQ-031 Reset loads M to identity: diagonal 1<<FRAC, others 0.
REQ-032 Reset mid-COMPUTE or DONE aborts the vector; no valid_out for it.
REQ-033 ready_out=1 first cycle after reset deassertion.

Verification (WIDTH=32, FRAC=16, DIM=4)
REQ-034 After reset, all pos_in=0x00010000, valid_in 1 cycle -> valid_out 16 cycles later, all new_pos_out=0x00010000, sat_out=0.
REQ-035 Write M[3][0]=0x00020000 in IDLE, all pos_in=1.0 -> new_pos_out[3]=0x00030000, others 0x00010000.
REQ-036 ready_in low 5 cycles in DONE -> valid_out stays 1, new_pos_out stable, ready_out=0, valid_in pulses ignored; ready_in with valid_in -> next vector accepted same edge.
REQ-037 M[1][1]=0x7FFF0000, pos_in[1]=0x00020000 -> new_pos_out[1]=0x7FFFFFFF, sat_out=1; next unsaturated vector -> sat_out=0.
REQ-038 Write M[0][0]=0 during COMPUTE -> ignored, result unchanged; reset 5 cycles into COMPUTE -> no valid_out, M identity again.
